// File: rtl/stim_harness_pkg.sv
// Shared widths, tap constants and state encoding for the stimulus/capture harness.
package stim_harness_pkg;

    localparam int IN_W  = 12;
    localparam int OUT_W = 17;

    localparam logic [IN_W-1:0]  LFSR_TAPS = 12'hE08;
    localparam logic [OUT_W-1:0] MISR_TAPS = 17'h12000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } harness_state_e;

    // One MISR step: shift with x^17+x^14+1 feedback, then fold in the response.
    function automatic logic [OUT_W-1:0] misr_step(input logic [OUT_W-1:0] sig,
                                                    input logic [OUT_W-1:0] din);
        return {sig[OUT_W-2:0], ^(sig & MISR_TAPS)} ^ din;
    endfunction

endpackage

// File: rtl/harness_lfsr12.sv
// 12-bit Fibonacci LFSR (x^12+x^11+x^10+x^4+1) with load/advance enables.
module harness_lfsr12
    import stim_harness_pkg::*;
#(
    parameter logic [IN_W-1:0] SEED = 12'h001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_adv,
    output logic [IN_W-1:0] o_q
);

    // An all-zero state would lock the LFSR, so a zero seed falls back to 1.
    localparam logic [IN_W-1:0] SEED_SAFE = (SEED == '0) ? 12'h001 : SEED;

    logic [IN_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_load)
            r_q <= SEED_SAFE;
        else if (i_adv)
            r_q <= {r_q[IN_W-2:0], ^(r_q & LFSR_TAPS)};
    end

    assign o_q = r_q;

endmodule

// File: rtl/stim_capture_harness.sv
// Drives LFSR stimulus into a combinational datapath and compacts responses in a MISR.
// Define GOLDEN_CHECK_EN to add expected_sig/pass signature comparison.
module stim_capture_harness
    import stim_harness_pkg::*;
#(
    parameter int               NUM_VECTORS = 256,
    parameter logic [IN_W-1:0]  SEED        = 12'h001,
    parameter int               CAPTURE_LAT = 1,
    parameter logic [OUT_W-1:0] MISR_INIT   = 17'h00000,
    localparam int              CNT_W       = $clog2(NUM_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [OUT_W-1:0] signature
`ifdef GOLDEN_CHECK_EN
    ,
    input  logic [OUT_W-1:0] expected_sig,
    output logic             pass
`endif
);

    localparam int                SET_W       = $clog2(CAPTURE_LAT + 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(CAPTURE_LAT - 1);
    localparam logic [CNT_W-1:0]  LAST_VEC    = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0]  MAX_CNT     = CNT_W'(NUM_VECTORS);

    harness_state_e   r_state;
    logic [SET_W-1:0] r_settle;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_count;
    logic [OUT_W-1:0] r_sig;
`ifdef GOLDEN_CHECK_EN
    logic             r_pass;
`endif

    logic             w_idle_like;
    logic             w_load;
    logic             w_adv;
    logic [OUT_W-1:0] w_sig_next;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_load      = !abort && start && w_idle_like;
    assign w_adv       = !abort && (r_state == ST_CAPTURE);
    assign w_sig_next  = misr_step(r_sig, dut_out);

    harness_lfsr12 #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_adv  (w_adv),
        .o_q    (dut_in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_settle <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_count  <= '0;
            r_sig    <= MISR_INIT;
`ifdef GOLDEN_CHECK_EN
            r_pass   <= 1'b0;
`endif
        end else if (abort) begin
            // Partial signature and count are left visible for debug.
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef GOLDEN_CHECK_EN
            r_pass  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= ST_SETTLE;
                        r_settle <= '0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_count  <= '0;
                        r_sig    <= MISR_INIT;
`ifdef GOLDEN_CHECK_EN
                        r_pass   <= 1'b0;
`endif
                    end
                end
                ST_SETTLE: begin
                    if (r_settle == SETTLE_LAST)
                        r_state <= ST_CAPTURE;
                    else
                        r_settle <= r_settle + 1'b1;
                end
                ST_CAPTURE: begin
                    r_sig <= w_sig_next;
                    if (r_count != MAX_CNT)
                        r_count <= r_count + 1'b1;
                    if (r_count >= LAST_VEC) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef GOLDEN_CHECK_EN
                        r_pass  <= (w_sig_next == expected_sig);
`endif
                    end else begin
                        r_state  <= ST_SETTLE;
                        r_settle <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign vec_count = r_count;
    assign signature = r_sig;
`ifdef GOLDEN_CHECK_EN
    assign pass      = r_pass;
`endif

endmodule

// File: tb/tb_stim_capture_harness.sv
// Randomized scoreboard bench for stim_capture_harness with a bench-side datapath model.
module tb_stim_capture_harness;

    localparam int          NV    = 5;
    localparam int          LAT   = 1;
    localparam logic [11:0] SEED  = 12'h000;
    localparam logic [16:0] MINIT = 17'h00000;
    localparam int          RUN   = NV * (LAT + 1);
    localparam int          CW    = $clog2(NV + 1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [11:0]   dut_in;
    logic [16:0]   dut_out;
    logic          busy, done;
    logic [CW-1:0] vec_count;
    logic [16:0]   signature;
`ifdef GOLDEN_CHECK_EN
    logic [16:0]   expected_sig = '0;
    logic          pass;
`endif

    int          n_cmp = 0;
    int          n_bad = 0;
    int          dp_mode = 0;
    logic [16:0] dp_key = '0;

    always #5 clk = ~clk;

    // Bench stand-in for a generated datapath: zero, loopback, or keyed mixing.
    function automatic logic [16:0] dp_model(input logic [11:0] x, input int mode,
                                             input logic [16:0] key);
        logic [11:0] y;
        y = x * 12'd3;
        case (mode)
            0:       return '0;
            1:       return {5'b0, x};
            default: return {x[4:0] ^ key[16:12], y ^ key[11:0]};
        endcase
    endfunction

    assign dut_out = dp_model(dut_in, dp_mode, dp_key);

    stim_capture_harness #(
        .NUM_VECTORS (NV),
        .SEED        (SEED),
        .CAPTURE_LAT (LAT),
        .MISR_INIT   (MINIT)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .vec_count (vec_count),
        .signature (signature)
`ifdef GOLDEN_CHECK_EN
        ,
        .expected_sig (expected_sig),
        .pass         (pass)
`endif
    );

    // kind: 0 completes, 1 aborted at edge m, 2 reset mid-run
    typedef struct {
        int                   kind;
        int                   m;
        int                   cnt;
        logic [NV-1:0][11:0]  stim;
        logic [NV:0][16:0]    sig;
        logic                 exp_pass;
    } run_t;

    run_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic run_t build_run(input int kind, input int m);
        run_t        r;
        logic [11:0] x;
        logic [16:0] s;
        x = (SEED == 12'h000) ? 12'h001 : SEED;
        s = MINIT;
        r.kind = kind;
        r.m    = m;
        for (int k = 0; k < NV; k++) begin
            r.stim[k] = x;
            r.sig[k]  = s;
            s = {s[15:0], s[16] ^ s[13]} ^ dp_model(x, dp_mode, dp_key);
            x = {x[10:0], x[11] ^ x[10] ^ x[9] ^ x[3]};
        end
        r.sig[NV]  = s;
        r.cnt      = (kind == 0) ? NV : (kind == 1) ? (m - 1) / (LAT + 1) : 0;
        r.exp_pass = 1'b0;
        return r;
    endfunction

    initial begin : mon
        run_t cur;
        bit   act = 0;
        int   c = 0;
        int   v;
        forever begin
            @(negedge clk);
            if (!act) begin
                if (busy === 1'b1) begin
                    if (sb.size() == 0) chk("unexpected_busy", 32'(busy), 0);
                    else begin
                        cur = sb[0];
                        act = 1;
                        c   = 0;
                    end
                end
            end else c++;
            if (act) begin
                if (busy === 1'b1) begin
                    v = c / (LAT + 1);
                    if (v < NV) begin
                        chk("dut_in", 32'(dut_in), 32'(cur.stim[v]));
                        chk("vec_count_run", 32'(vec_count), v);
                        chk("sig_run", 32'(signature), 32'(cur.sig[v]));
                    end else chk("busy_overrun", 32'(busy), 0);
                    chk("done_in_busy", 32'(done), 0);
`ifdef GOLDEN_CHECK_EN
                    chk("pass_in_busy", 32'(pass), 0);
`endif
                end else begin
                    void'(sb.pop_front());
                    act = 0;
                    chk("end_kind", (done === 1'b1) ? 0 : 1, (cur.kind == 0) ? 0 : 1);
                    if (cur.kind != 2) chk("end_cycle", c, cur.m);
                    chk("final_cnt", 32'(vec_count), cur.cnt);
                    chk("final_sig", 32'(signature), 32'(cur.sig[cur.cnt]));
`ifdef GOLDEN_CHECK_EN
                    chk("pass", 32'(pass), (cur.kind == 0) ? 32'(cur.exp_pass) : 0);
`endif
                end
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_dut_in"}, 32'(dut_in), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_vec_count"}, 32'(vec_count), 0);
        chk({tag, "_signature"}, 32'(signature), 32'(MINIT));
`ifdef GOLDEN_CHECK_EN
        chk({tag, "_pass"}, 32'(pass), 0);
`endif
    endtask

    task automatic run_one(input int kind);
        run_t r;
        int   m;
        int   sp;
        m = (kind == 1) ? $urandom_range(1, RUN - 1) :
            (kind == 2) ? $urandom_range(1, RUN - 2) : RUN;
        r = build_run(kind, m);
`ifdef GOLDEN_CHECK_EN
        expected_sig = ($urandom_range(0, 1) == 1) ? r.sig[NV] : (r.sig[NV] ^ 17'h00001);
        r.exp_pass   = (expected_sig == r.sig[NV]);
`endif
        sb.push_back(r);
        sp = (kind == 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, RUN - 2) : -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c <= RUN + 1; c++) begin
            if (kind == 1 && c == m - 1) begin
                abort = 1'b1;
                start = ($urandom_range(0, 1) == 1);
            end else if (kind == 1 && c == m) begin
                abort = 1'b0;
                start = 1'b0;
            end
            if (sp >= 0 && c == sp) start = 1'b1;
            else if (sp >= 0 && c == sp + 1) start = 1'b0;
            if (kind == 2 && c == m) begin
                #2 rst_n = 1'b0;
                #1 chk_reset_vals("midrun_reset");
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if (kind == 1 && c > m) break;
            @(negedge clk);
        end
        for (int w = 0; w < RUN + 20 && sb.size() != 0; w++) @(negedge clk);
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL run_timeout: %0d runs still pending, want 0", sb.size());
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    endtask

    initial begin : drv
        int kind;
        #1 rst_n = 1'b0;
        #2 chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int it = 0; it < 30; it++) begin
            if (it < 3) begin
                dp_mode = it;
                kind    = 0;
            end else begin
                dp_mode = $urandom_range(0, 2);
                dp_key  = 17'($urandom);
                kind    = ($urandom_range(0, 3) == 0) ? 1 : 0;
                if (it == 12 || it == 21) kind = 2;
                if (it == 5) kind = 1;
            end
            run_one(kind);
            if ($urandom_range(0, 2) == 0) repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
